// File: rtl/fl_slr_crossing_dst.sv
// Destination end of a credit-based FrameLink SLR crossing: input flop stage,
// FWFT buffer sized to the credit pool, credit return FSM and sticky error flags.
module fl_slr_crossing_dst #(
    parameter int DATA_WIDTH = 64,
    parameter int DREM_WIDTH = 3,
    parameter int CREDITS    = 8
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic [DATA_WIDTH-1:0] RX_DATA,
    input  logic [DREM_WIDTH-1:0] RX_REM,
    input  logic                  RX_SOF_N,
    input  logic                  RX_EOF_N,
    input  logic                  RX_SOP_N,
    input  logic                  RX_EOP_N,
    input  logic                  RX_SRC_RDY_N,
    output logic                  RX_CREDIT,
    output logic [DATA_WIDTH-1:0] TX_DATA,
    output logic [DREM_WIDTH-1:0] TX_REM,
    output logic                  TX_SOF_N,
    output logic                  TX_EOF_N,
    output logic                  TX_SOP_N,
    output logic                  TX_EOP_N,
    output logic                  TX_SRC_RDY_N,
    input  logic                  TX_DST_RDY_N,
    output logic                  OVERFLOW,
    output logic                  FRAME_ERR
);

    localparam int PW = $clog2(CREDITS);
    localparam int CW = PW + 1;
    localparam int EW = DATA_WIDTH + DREM_WIDTH + 4;
    localparam logic [CW-1:0] FULL = CW'(CREDITS);

    typedef enum logic {INIT, RUN} state_e;

    // Word layout: {DATA, REM, SOF_N, EOF_N, SOP_N, EOP_N}
    logic [EW-1:0] rx_word_q;
    logic          rx_src_rdy_n_q;

    always_ff @(posedge CLK) begin
        rx_word_q <= {RX_DATA, RX_REM, RX_SOF_N, RX_EOF_N, RX_SOP_N, RX_EOP_N};
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) rx_src_rdy_n_q <= 1'b1;
        else          rx_src_rdy_n_q <= RX_SRC_RDY_N;
    end

    logic [EW-1:0] mem_q [CREDITS];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_req, wr_en, pop, empty, full;

    assign wr_req = !rx_src_rdy_n_q;
    assign empty  = (cnt_q == '0);
    assign full   = (cnt_q == FULL);
    assign pop    = !empty && !TX_DST_RDY_N;
    // A pop frees the head slot in the same cycle, so a full buffer still takes the write.
    assign wr_en  = wr_req && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
        if (wr_en && !pop)      cnt_d = cnt_q + CW'(1);
        else if (pop && !wr_en) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) mem_q[wr_ptr_q] <= rx_word_q;
    end

    logic [EW-1:0] head;
    assign head         = mem_q[rd_ptr_q];
    assign TX_SRC_RDY_N = empty;
    assign TX_DATA      = head[EW-1 -: DATA_WIDTH];
    assign TX_REM       = head[4 +: DREM_WIDTH];
    assign TX_SOF_N     = empty | head[3];
    assign TX_EOF_N     = empty | head[2];
    assign TX_SOP_N     = empty | head[1];
    assign TX_EOP_N     = empty | head[0];

    // Delimiter checker observes the flopped RX word only; it never touches the data path.
    logic in_frame_q, in_frame_d, frame_viol;
    logic sof_n, eof_n, eop_n;
    assign sof_n = rx_word_q[3];
    assign eof_n = rx_word_q[2];
    assign eop_n = rx_word_q[0];

    always_comb begin
        in_frame_d = in_frame_q;
        frame_viol = 1'b0;
        if (wr_req) begin
            frame_viol = (!sof_n && in_frame_q) || (!in_frame_q && sof_n) || (!eof_n && eop_n);
            if (!eof_n)      in_frame_d = 1'b0;
            else if (!sof_n) in_frame_d = 1'b1;
        end
    end

    logic overflow_q, frame_err_q;
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            in_frame_q  <= 1'b0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            in_frame_q  <= in_frame_d;
            overflow_q  <= overflow_q | (wr_req && full && !pop);
            frame_err_q <= frame_err_q | frame_viol;
        end
    end

    assign OVERFLOW  = overflow_q;
    assign FRAME_ERR = frame_err_q;

    // INIT hands the whole credit pool to the source, one pulse per cycle.
    state_e        state_q;
    logic [CW-1:0] init_cnt_q;
    logic          credit_q;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
            credit_q   <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    credit_q   <= 1'b1;
                    init_cnt_q <= init_cnt_q + CW'(1);
                    if (init_cnt_q == CW'(CREDITS - 1)) state_q <= RUN;
                end
                RUN:     credit_q <= pop;
                default: state_q  <= INIT;
            endcase
        end
    end

    assign RX_CREDIT = credit_q;

endmodule

// File: tb/tb_fl_slr_crossing_dst.sv
// Self-checking bench for fl_slr_crossing_dst: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_fl_slr_crossing_dst;

    localparam int DW = 64;
    localparam int RW = 3;
    localparam int CR = 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [RW-1:0] rem;
        logic          sof_n;
        logic          eof_n;
        logic          sop_n;
        logic          eop_n;
    } word_t;

    typedef struct {
        logic  vld;
        word_t w;
        logic  exp_tx_vld;
        logic  exp_credit;
        int    exp_idx;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    word_t         rx_w = '0;
    logic          rx_src_rdy_n = 1'b1;
    logic          dst_rdy_n = 1'b1;
    logic          rx_credit;
    logic [DW-1:0] tx_data;
    logic [RW-1:0] tx_rem;
    logic          tx_sof_n, tx_eof_n, tx_sop_n, tx_eop_n, tx_src_rdy_n;
    logic          overflow, frame_err;
    word_t         tx_w;

    assign tx_w = {tx_data, tx_rem, tx_sof_n, tx_eof_n, tx_sop_n, tx_eop_n};

    always #5 clk = ~clk;

    fl_slr_crossing_dst #(.DATA_WIDTH(DW), .DREM_WIDTH(RW), .CREDITS(CR)) dut (
        .CLK(clk), .RESET_N(rst_n),
        .RX_DATA(rx_w.data), .RX_REM(rx_w.rem),
        .RX_SOF_N(rx_w.sof_n), .RX_EOF_N(rx_w.eof_n),
        .RX_SOP_N(rx_w.sop_n), .RX_EOP_N(rx_w.eop_n),
        .RX_SRC_RDY_N(rx_src_rdy_n), .RX_CREDIT(rx_credit),
        .TX_DATA(tx_data), .TX_REM(tx_rem),
        .TX_SOF_N(tx_sof_n), .TX_EOF_N(tx_eof_n),
        .TX_SOP_N(tx_sop_n), .TX_EOP_N(tx_eop_n),
        .TX_SRC_RDY_N(tx_src_rdy_n), .TX_DST_RDY_N(dst_rdy_n),
        .OVERFLOW(overflow), .FRAME_ERR(frame_err)
    );

    int n_chk = 0;
    int n_err = 0;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: buffer contents as a queue, one pending word for the input flop,
    // credits derived from the cycle count since reset release and the previous pop.
    word_t m_q[$];
    logic  m_pend_v = 1'b0;
    word_t m_pend = '0;
    int    m_since = 0;
    logic  m_credit = 1'b0, m_ovf = 1'b0, m_ferr = 1'b0, m_in_frame = 1'b0;
    word_t watch_w = '0;
    int    watch_seen = 0;

    task automatic model_edge();
        logic pop;
        if (!rst_n) begin
            m_q.delete();
            m_pend_v = 1'b0;
            m_since = 0;
            m_credit = 1'b0;
            m_ovf = 1'b0;
            m_ferr = 1'b0;
            m_in_frame = 1'b0;
        end else begin
            pop = (m_q.size() != 0) && !dst_rdy_n;
            if (pop) void'(m_q.pop_front());
            if (m_pend_v) begin
                if (m_q.size() >= CR) m_ovf = 1'b1;
                else m_q.push_back(m_pend);
                if ((!m_pend.sof_n && m_in_frame) || (!m_in_frame && m_pend.sof_n) ||
                    (!m_pend.eof_n && m_pend.eop_n))
                    m_ferr = 1'b1;
                if (!m_pend.eof_n) m_in_frame = 1'b0;
                else if (!m_pend.sof_n) m_in_frame = 1'b1;
            end
            m_since++;
            m_credit = (m_since <= CR) ? 1'b1 : pop;
        end
        m_pend_v = rst_n && !rx_src_rdy_n;
        m_pend = rx_w;
    endtask

    task automatic check_model();
        chk("tx_vld", !tx_src_rdy_n, m_q.size() != 0);
        if (m_q.size() != 0) chk("tx_word", tx_w, m_q[0]);
        chk("credit", rx_credit, m_credit);
        chk("overflow", overflow, m_ovf);
        chk("frame_err", frame_err, m_ferr);
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        check_model();
        if (!tx_src_rdy_n && tx_w == watch_w) watch_seen++;
    endtask

    task automatic send(input word_t w);
        rx_w = w;
        rx_src_rdy_n = 1'b0;
        cycle();
        rx_src_rdy_n = 1'b1;
    endtask

    task automatic idle(input int n);
        rx_src_rdy_n = 1'b1;
        repeat (n) cycle();
    endtask

    function automatic word_t mk(logic [63:0] d, logic [2:0] r,
                                 logic sof, logic eof, logic sop, logic eop);
        word_t w;
        w.data = d;
        w.rem = r;
        w.sof_n = ~sof;
        w.eof_n = ~eof;
        w.sop_n = ~sop;
        w.eop_n = ~eop;
        return w;
    endfunction

    initial begin
        vec_t  tbl[6];
        word_t f[3];
        int    cnt, vld_seen;

        f[0] = mk(64'h1111_2222_3333_0001, 3'd0, 1, 0, 1, 0);
        f[1] = mk(64'h1111_2222_3333_0002, 3'd7, 0, 0, 0, 0);
        f[2] = mk(64'h1111_2222_3333_0003, 3'd5, 0, 1, 0, 1);
        tbl[0] = '{1'b1, f[0], 1'b0, 1'b0, -1};
        tbl[1] = '{1'b1, f[1], 1'b1, 1'b0,  0};
        tbl[2] = '{1'b1, f[2], 1'b1, 1'b1,  1};
        tbl[3] = '{1'b0, f[2], 1'b1, 1'b1,  2};
        tbl[4] = '{1'b0, f[2], 1'b0, 1'b1, -1};
        tbl[5] = '{1'b0, f[2], 1'b0, 1'b0, -1};

        // Reset state
        rst_n = 1'b0;
        cycle();
        cycle();
        chk("rst_tx_vld_n", tx_src_rdy_n, 1'b1);
        chk("rst_credit", rx_credit, 1'b0);
        chk("rst_delims", {tx_sof_n, tx_eof_n, tx_sop_n, tx_eop_n}, 4'hF);
        chk("rst_flags", {overflow, frame_err}, 2'b00);

        // Initial credit burst
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 1; c <= 12; c++) begin
            cycle();
            chk("init_credit", rx_credit, c <= CR);
            chk("init_tx_idle", tx_src_rdy_n, 1'b1);
            cnt += int'(rx_credit);
        end
        chk("init_pulses", cnt, CR);

        // Single 3-word frame, vector table
        dst_rdy_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rx_w = tbl[i].w;
            rx_src_rdy_n = !tbl[i].vld;
            cycle();
            chk("tbl_tx_vld", !tx_src_rdy_n, tbl[i].exp_tx_vld);
            chk("tbl_credit", rx_credit, tbl[i].exp_credit);
            if (tbl[i].exp_idx >= 0) chk("tbl_tx_word", tx_w, f[tbl[i].exp_idx]);
        end
        rx_src_rdy_n = 1'b1;
        chk("tbl_frame_err", frame_err, 1'b0);

        // Fill to full with the sink stalled, then a 9th word with no pop
        dst_rdy_n = 1'b1;
        for (int i = 0; i < CR; i++)
            send(mk(64'hA000 + 64'(i), 3'd7, i == 0, i == CR - 1, i == 0, i == CR - 1));
        idle(3);
        chk("full_vld", tx_src_rdy_n, 1'b0);
        chk("full_head", tx_data, 64'hA000);
        chk("full_no_ovf", overflow, 1'b0);
        send(mk(64'hB009, 3'd1, 1, 1, 1, 1));
        idle(2);
        chk("ovf_set", overflow, 1'b1);
        dst_rdy_n = 1'b0;
        cnt = 0;
        repeat (12) begin
            cycle();
            cnt += int'(rx_credit);
        end
        chk("drain_credits", cnt, CR);
        chk("ovf_sticky", overflow, 1'b1);
        chk("drain_empty", tx_src_rdy_n, 1'b1);

        // Refill; 9th word lands in the same cycle as a pop
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        idle(10);
        chk("ovf_cleared", overflow, 1'b0);
        dst_rdy_n = 1'b1;
        for (int i = 0; i < CR; i++)
            send(mk(64'hC000 + 64'(i), 3'd7, i == 0, i == CR - 1, i == 0, i == CR - 1));
        idle(2);
        watch_w = mk(64'hC009, 3'd2, 1, 1, 1, 1);
        watch_seen = 0;
        send(watch_w);
        dst_rdy_n = 1'b0;
        cnt = 0;
        repeat (14) begin
            cycle();
            cnt += int'(rx_credit);
        end
        chk("full_pop_credits", cnt, CR + 1);
        chk("full_pop_no_ovf", overflow, 1'b0);
        chk("full_pop_delivered", watch_seen > 0, 1'b1);

        // Reset with four words buffered mid-frame and a word on RX
        dst_rdy_n = 1'b1;
        for (int i = 0; i < 4; i++) send(mk(64'hD000 + 64'(i), 3'd7, 0, 0, 0, 0));
        idle(2);
        chk("mid_ferr", frame_err, 1'b1);
        chk("mid_vld", tx_src_rdy_n, 1'b0);
        rx_w = mk(64'hDEAD, 3'd7, 1, 0, 1, 0);
        rx_src_rdy_n = 1'b0;
        rst_n = 1'b0;
        cycle();
        rx_src_rdy_n = 1'b1;
        rst_n = 1'b1;
        chk("mid_rst_vld_n", tx_src_rdy_n, 1'b1);
        chk("mid_rst_flags", {overflow, frame_err}, 2'b00);
        chk("mid_rst_credit", rx_credit, 1'b0);
        cnt = 0;
        vld_seen = 0;
        repeat (12) begin
            cycle();
            cnt += int'(rx_credit);
            vld_seen += int'(!tx_src_rdy_n);
        end
        chk("mid_init_pulses", cnt, CR);
        chk("mid_no_stale", vld_seen, 0);

        // SOF inside a frame flags an error but the word still goes through
        dst_rdy_n = 1'b0;
        watch_w = mk(64'hE002, 3'd3, 1, 0, 1, 0);
        watch_seen = 0;
        send(mk(64'hE001, 3'd7, 1, 0, 1, 0));
        send(watch_w);
        send(mk(64'hE003, 3'd4, 0, 1, 0, 1));
        idle(4);
        chk("sof_in_frame_err", frame_err, 1'b1);
        chk("sof_in_frame_delivered", watch_seen, 1);

        // Randomized traffic against the model
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            int kind;
            rst_n = ($urandom_range(0, 599) != 0);
            rx_src_rdy_n = $urandom_range(0, 1) != 0;
            dst_rdy_n = ($urandom_range(0, 9) < 3);
            rx_w.data = {$urandom, $urandom};
            rx_w.rem = 3'($urandom_range(0, 7));
            kind = $urandom_range(0, 9);
            if (kind < 3)      {rx_w.sof_n, rx_w.eof_n, rx_w.sop_n, rx_w.eop_n} = 4'b0101;
            else if (kind < 6) {rx_w.sof_n, rx_w.eof_n, rx_w.sop_n, rx_w.eop_n} = 4'b1111;
            else if (kind < 9) {rx_w.sof_n, rx_w.eof_n, rx_w.sop_n, rx_w.eop_n} = 4'b1010;
            else               {rx_w.sof_n, rx_w.eof_n, rx_w.sop_n, rx_w.eop_n} = 4'($urandom_range(0, 15));
            cycle();
        end
        rst_n = 1'b1;
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
